// File: rtl/intctl_pkg.sv
// rtl/intctl_pkg.sv - shared types and constants for the interrupt controller
//
// Purpose: state encoding, device-count limit, vector width and the select
// width helper used by int_controller and intctl_prio_enc.
// Ports: none (package).
// Optional feature macro used by the design files: INTCTL_RR_EN.

package intctl_pkg;

    localparam int INTCTL_MAX_DEV = 16;
    localparam int VEC_W          = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } intctl_state_t;

    // A single-device build still needs a 1-bit select.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - device/processor side signals of the interrupt controller
//
// Purpose: bundles the request, acknowledge and vector lines.
// Signals:
//   Irq    [N_DEV] device request lines (rising edge = one request)
//   IntAck          processor acknowledge level
//   OnInt           interrupt request to the micro-controller
//   DrVec           vector valid, processor gates Vec onto its bus
//   Vec    [32]     granted vector, zero when DrVec is low
//   DevAck [N_DEV]  one-cycle one-hot acknowledge to the granted device
// Modports: master = processor/devices side, slave = controller side.

interface int_controller_if #(
    parameter int N_DEV = 8
);
    logic [N_DEV-1:0] Irq;
    logic             IntAck;
    logic             OnInt;
    logic             DrVec;
    logic [31:0]      Vec;
    logic [N_DEV-1:0] DevAck;

    modport master (
        output Irq, IntAck,
        input  OnInt, DrVec, Vec, DevAck
    );

    modport slave (
        input  Irq, IntAck,
        output OnInt, DrVec, Vec, DevAck
    );
endinterface

// File: rtl/intctl_prio_enc.sv
// rtl/intctl_prio_enc.sv - combinational priority encoder over the pending bits
//
// Purpose: picks the winning device index from a request vector.
// Ports:
//   req   [N_DEV]  pending request bits
//   start [IDX_W]  first index searched (only with INTCTL_RR_EN)
//   any            at least one request present
//   idx   [IDX_W]  winning index (0 when any is low)
// Macro INTCTL_RR_EN: rotating search starting at start; otherwise the
// lowest index wins.

module intctl_prio_enc
    import intctl_pkg::*;
#(
    parameter int N_DEV = 8,
    parameter int IDX_W = idx_width(N_DEV)
) (
    input  logic [N_DEV-1:0] req,
`ifdef INTCTL_RR_EN
    input  logic [IDX_W-1:0] start,
`endif
    output logic             any,
    output logic [IDX_W-1:0] idx
);

`ifdef INTCTL_RR_EN
    // Walk offsets from the far end down so the smallest offset from start
    // is the last one written and therefore wins.
    always_comb begin
        int j;
        any = |req;
        idx = '0;
        j   = 0;
        for (int off = N_DEV - 1; off >= 0; off--) begin
            j = int'(start) + off;
            if (j >= N_DEV) begin
                j = j - N_DEV;
            end
            if (req[IDX_W'(j)]) begin
                idx = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) begin
                idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - edge-triggered interrupt responder with vectored acknowledge
//
// Purpose: latches device request edges, raises OnInt, and on a rising
// IntAck drives the winning device's vector and a one-cycle DevAck.
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   bus        int_controller_if.slave (Irq, IntAck in; OnInt, DrVec, Vec, DevAck out)
// Parameters: N_DEV (1..16 devices), VEC_BASE (vector of device 0).
// Macro INTCTL_RR_EN: round-robin priority with a last_sel register;
// undefined gives fixed lowest-index priority.

module int_controller
    import intctl_pkg::*;
#(
    parameter int               N_DEV    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    int_controller_if.slave   bus
);

    localparam int IDX_W = idx_width(N_DEV);

    intctl_state_t    state;
    intctl_state_t    next_state;

    logic [N_DEV-1:0] irq_q;
    logic [N_DEV-1:0] irq_rise;
    logic [N_DEV-1:0] pending;
    logic [N_DEV-1:0] pending_d;
    logic             ack_q;
    logic             ack_rise;
    logic             grant;

    logic             any;
    logic [IDX_W-1:0] idx;

    logic             on_int_d;
    logic             dr_vec_d;
    logic [VEC_W-1:0] vec_d;
    logic [N_DEV-1:0] dev_ack_d;

    logic             on_int_r;
    logic             dr_vec_r;
    logic [VEC_W-1:0] vec_r;
    logic [N_DEV-1:0] dev_ack_r;

`ifdef INTCTL_RR_EN
    logic [IDX_W-1:0] last_sel;
    logic [IDX_W-1:0] start;

    assign start = (int'(last_sel) == N_DEV - 1) ? '0 : last_sel + 1'b1;

    intctl_prio_enc #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (pending),
        .start (start),
        .any   (any),
        .idx   (idx)
    );
`else
    intctl_prio_enc #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (pending),
        .any   (any),
        .idx   (idx)
    );
`endif

    assign irq_rise = bus.Irq & ~irq_q;
    // ack_q follows IntAck in every state, so a level already high when
    // REQ is entered never looks like a fresh acknowledge.
    assign ack_rise = bus.IntAck & ~ack_q;

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (!any) begin
                    next_state = IDLE;
                end else if (ack_rise) begin
                    next_state = GRANT;
                    grant      = 1'b1;
                end
            end
            GRANT: begin
                next_state = RELEASE;
            end
            RELEASE: begin
                if (!bus.IntAck) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Clear first, then OR in new edges: a re-request landing on the
        // grant edge stays pending.
        pending_d = pending;
        if (grant) begin
            pending_d[idx] = 1'b0;
        end
        pending_d = pending_d | irq_rise;

        // Outputs are registered from the next state, so the grant lines
        // appear for exactly the cycle spent in GRANT; the output registers
        // also serve as the latched selection.
        on_int_d  = (next_state == REQ);
        dr_vec_d  = grant;
        vec_d     = '0;
        dev_ack_d = '0;
        if (grant) begin
            vec_d          = VEC_BASE + {{(VEC_W - IDX_W){1'b0}}, idx};
            dev_ack_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= '0;
            ack_q     <= 1'b0;
            pending   <= '0;
            on_int_r  <= 1'b0;
            dr_vec_r  <= 1'b0;
            vec_r     <= '0;
            dev_ack_r <= '0;
        end else begin
            irq_q     <= bus.Irq;
            ack_q     <= bus.IntAck;
            pending   <= pending_d;
            on_int_r  <= on_int_d;
            dr_vec_r  <= dr_vec_d;
            vec_r     <= vec_d;
            dev_ack_r <= dev_ack_d;
        end
    end

`ifdef INTCTL_RR_EN
    // Reset to the last index so the first search after reset starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel <= IDX_W'(N_DEV - 1);
        end else if (grant) begin
            last_sel <= idx;
        end
    end
`endif

    assign bus.OnInt  = on_int_r;
    assign bus.DrVec  = dr_vec_r;
    assign bus.Vec    = vec_r;
    assign bus.DevAck = dev_ack_r;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - scoreboard bench for int_controller

module tb_int_controller;

    localparam int          N  = 8;
    localparam logic [31:0] VB = 32'h0000_0100;

    typedef struct {
        logic [31:0]  vec;
        logic [N-1:0] ack;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    exp_t         q[$];
    logic [N-1:0] pend_m;
    int           last_m;

    int_controller_if #(.N_DEV(N)) bus ();

    int_controller #(
        .N_DEV    (N),
        .VEC_BASE (VB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference priority: lowest pending index, or with round-robin the
    // first pending index after the previously granted one.
    function automatic int pick();
`ifdef INTCTL_RR_EN
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (last_m + off) % N;
            if (pend_m[i]) return i;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (pend_m[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        pend_m = '0;
        last_m = N - 1;
    endtask

    task automatic raise_mask(input logic [N-1:0] m);
        logic [N-1:0] r;
        r       = m & ~bus.Irq;
        bus.Irq = bus.Irq | r;
        pend_m  = pend_m | r;
    endtask

    task automatic lower_mask(input logic [N-1:0] m);
        bus.Irq = bus.Irq & ~m;
    endtask

    task automatic ack_on(input bit expect_grant);
        int           w;
        exp_t         e;
        if (expect_grant) begin
            w = pick();
            if (w >= 0) begin
                e.vec     = VB + 32'(w);
                e.ack     = '0;
                e.ack[w]  = 1'b1;
                e.cyc     = cyc + 1;
                q.push_back(e);
                pend_m[w] = 1'b0;
                last_m    = w;
            end
        end
        bus.IntAck = 1'b1;
    endtask

    task automatic wait_onint(input string name);
        int k;
        k = 0;
        while (bus.OnInt !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        check(name, {31'd0, bus.OnInt}, 32'd1);
    endtask

    // Monitor: every cycle with DrVec high consumes one expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (bus.DrVec === 1'b1) begin
            check("grant_onint_low", {31'd0, bus.OnInt}, 32'd0);
            if (q.size() == 0) begin
                check("drvec_unexpected", {31'd0, bus.DrVec}, 32'd0);
            end else begin
                e = q.pop_front();
                check("grant_vec", bus.Vec, e.vec);
                check("grant_devack", 32'(bus.DevAck), 32'(e.ack));
                check("grant_cycle", cyc, e.cyc);
            end
        end else begin
            check("idle_vec_zero", bus.Vec, 32'd0);
            check("idle_devack_zero", 32'(bus.DevAck), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        bus.Irq    = '0;
        bus.IntAck = 1'b0;
        model_reset();
        step(3);
        check("rst_onint", {31'd0, bus.OnInt}, 32'd0);
        check("rst_drvec", {31'd0, bus.DrVec}, 32'd0);
        check("rst_vec", bus.Vec, 32'd0);
        check("rst_devack", 32'(bus.DevAck), 32'd0);
        rst = 1'b0;
        step(2);

        // Single request: OnInt two edges after the request edge.
        raise_mask(8'h08);
        step(1);
        check("single_onint_early", {31'd0, bus.OnInt}, 32'd0);
        step(1);
        check("single_onint_on", {31'd0, bus.OnInt}, 32'd1);
        ack_on(1);
        step(1);
        check("single_onint_grant", {31'd0, bus.OnInt}, 32'd0);
        step(1);
        bus.IntAck = 1'b0;
        step(3);
        check("single_onint_after", {31'd0, bus.OnInt}, 32'd0);
        lower_mask(8'h08);
        step(1);

        // Simultaneous requests 1 and 5.
        raise_mask(8'h22);
        wait_onint("simul_onint1");
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(1);
        wait_onint("simul_onint2");
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(2);
        lower_mask(8'h22);
        step(1);

        // Late higher-priority arrival competes; OnInt returns after release.
        raise_mask(8'h40);
        wait_onint("late_onint");
        raise_mask(8'h01);
        step(1);
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(1);
        check("late_release_low", {31'd0, bus.OnInt}, 32'd0);
        step(1);
        check("late_reassert", {31'd0, bus.OnInt}, 32'd1);
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(2);
        lower_mask(8'h41);
        step(1);

        // Spurious ack in IDLE, held across a new request: no grant.
        bus.IntAck = 1'b1;
        step(2);
        raise_mask(8'h04);
        step(5);
        check("held_ack_onint", {31'd0, bus.OnInt}, 32'd1);
        bus.IntAck = 1'b0;
        step(1);
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(2);
        lower_mask(8'h04);
        step(1);

        // Re-request of device 4 landing on its own grant edge.
        raise_mask(8'h10);
        wait_onint("rereq_onint1");
        lower_mask(8'h10);
        step(1);
        ack_on(1);
        raise_mask(8'h10);
        step(1);
        bus.IntAck = 1'b0;
        step(1);
        wait_onint("rereq_onint2");
        ack_on(1);
        step(2);
        bus.IntAck = 1'b0;
        step(2);
        lower_mask(8'h10);
        step(1);

        // Reset in the GRANT cycle.
        raise_mask(8'h80);
        wait_onint("rstg_onint");
        ack_on(1);
        step(1);
        rst        = 1'b1;
        bus.Irq    = '0;
        bus.IntAck = 1'b0;
        model_reset();
        step(1);
        check("rstg_onint", {31'd0, bus.OnInt}, 32'd0);
        check("rstg_drvec", {31'd0, bus.DrVec}, 32'd0);
        check("rstg_vec", bus.Vec, 32'd0);
        check("rstg_devack", 32'(bus.DevAck), 32'd0);
        rst = 1'b0;
        step(6);
        check("rstg_no_onint", {31'd0, bus.OnInt}, 32'd0);

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            lower_mask(N'($urandom));
            step(1);
            raise_mask(N'($urandom) & N'($urandom));
            step(1);
            if (pend_m == '0) begin
                step(3);
                check("rand_idle_onint", {31'd0, bus.OnInt}, 32'd0);
                continue;
            end
            wait_onint("rand_onint");
            if ($urandom_range(0, 1) == 1) begin
                m = N'($urandom);
                raise_mask(m & ~bus.Irq & N'(1 << $urandom_range(0, N - 1)));
                step(1);
            end
            ack_on(1);
            if ($urandom_range(0, 3) == 0) begin
                raise_mask(N'(1 << $urandom_range(0, N - 1)));
            end
            step($urandom_range(1, 3));
            bus.IntAck = 1'b0;
            step(2);
        end

        // Drain whatever is still pending.
        for (int r = 0; r < N + 2 && pend_m != '0; r++) begin
            wait_onint("drain_onint");
            ack_on(1);
            step(2);
            bus.IntAck = 1'b0;
            step(2);
        end
        step(4);
        check("final_onint", {31'd0, bus.OnInt}, 32'd0);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
